// File: rtl/shift_reg_pkg.sv
// Package: shift_reg_pkg
// Purpose: shared definitions for the universal shift register slice.
//   - mode_t and the MODE_* operation codes (3-bit)
//   - state_e, the burst FSM state encoding (ST_IDLE, ST_BUSY)
// Imported by the interface, the operation unit and the top level.
package shift_reg_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD = 3'd0;
  localparam mode_t MODE_SHR  = 3'd1;
  localparam mode_t MODE_SHL  = 3'd2;
  localparam mode_t MODE_LOAD = 3'd3;
  localparam mode_t MODE_ROR  = 3'd4;
  localparam mode_t MODE_ROL  = 3'd5;
  localparam mode_t MODE_ASR  = 3'd6;
  localparam mode_t MODE_CLR  = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/universal_shift_register_if.sv
// Interface: universal_shift_register_if
// Purpose: bundles the control/data signals of universal_shift_register.
// Signals:
//   en, mode, sin_r, sin_l, d_load, start, count  -- driven by the master
//   q, sout_r, sout_l, busy, done                  -- driven by the register
// Modports:
//   master -- the controlling side (drives the controls, reads status)
//   slave  -- the shift register itself
interface universal_shift_register_if
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) ();

  logic             en;
  mode_t            mode;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] d_load;
  logic             start;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] q;
  logic             sout_r;
  logic             sout_l;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, sin_r, sin_l, d_load, start, count,
    input  q, sout_r, sout_l, busy, done
  );

  modport slave (
    input  en, mode, sin_r, sin_l, d_load, start, count,
    output q, sout_r, sout_l, busy, done
  );

endinterface

// File: rtl/shift_op_unit.sv
// Module: shift_op_unit
// Purpose: combinational next-value generator for the shift register.
//   One instance serves both single-step and burst operation.
// Ports:
//   q_i       in  WIDTH  current register contents
//   mode_i    in  3      operation select (MODE_* codes)
//   sin_r_i   in  1      serial bit entering the MSB on SHR
//   sin_l_i   in  1      serial bit entering the LSB on SHL
//   d_load_i  in  WIDTH  parallel load data
//   q_next_o  out WIDTH  register value after applying mode_i
module shift_op_unit
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q_i,
  input  mode_t            mode_i,
  input  logic             sin_r_i,
  input  logic             sin_l_i,
  input  logic [WIDTH-1:0] d_load_i,
  output logic [WIDTH-1:0] q_next_o
);

  always_comb begin
    q_next_o = q_i;
    case (mode_i)
      MODE_HOLD: q_next_o = q_i;
      MODE_SHR:  q_next_o = {sin_r_i, q_i[WIDTH-1:1]};
      MODE_SHL:  q_next_o = {q_i[WIDTH-2:0], sin_l_i};
      MODE_LOAD: q_next_o = d_load_i;
      MODE_ROR:  q_next_o = {q_i[0], q_i[WIDTH-1:1]};
      MODE_ROL:  q_next_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      MODE_ASR:  q_next_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
      default:   q_next_o = '0;  // MODE_CLR
    endcase
  end

endmodule

// File: rtl/universal_shift_register.sv
// Module: universal_shift_register
// Purpose: WIDTH-bit universal shift register (shift left/right, rotate,
//   arithmetic shift right, parallel load, clear) with a burst engine that
//   repeats one latched operation for `count` cycles.
// Ports:
//   clk  in  1   rising-edge clock
//   rst  in  1   asynchronous, active-low reset
//   bus  slave modport of universal_shift_register_if:
//     en/mode/sin_r/sin_l/d_load  single-step controls and data
//     start/count                 burst launch and length (idle only)
//     q/sout_r/sout_l             register contents and outgoing serial bits
//     busy/done                   burst in progress / one-cycle completion pulse
module universal_shift_register
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input logic                       clk,
  input logic                       rst,
  universal_shift_register_if.slave bus
);

  state_e           state_q;
  mode_t            mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             done_q;
  mode_t            op_mode;

  // While busy the latched mode drives the shared operation unit; the
  // live mode input is ignored until the burst ends.
  assign op_mode = (state_q == ST_BUSY) ? mode_q : bus.mode;

  shift_op_unit #(
    .WIDTH (WIDTH)
  ) u_op (
    .q_i      (q_q),
    .mode_i   (op_mode),
    .sin_r_i  (bus.sin_r),
    .sin_l_i  (bus.sin_l),
    .d_load_i (bus.d_load),
    .q_next_o (q_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_HOLD;
      cnt_q   <= '0;
      q_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // start outranks en; the launching edge performs no operation.
          if (bus.start) begin
            mode_q <= bus.mode;
            cnt_q  <= bus.count;
            if (bus.count == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= ST_BUSY;
            end
          end else if (bus.en) begin
            q_q <= q_d;
          end
        end
        ST_BUSY: begin
          q_q   <= q_d;
          cnt_q <= cnt_q - CNT_W'(1);
          // Last repetition: leave BUSY and raise done on the same edge so
          // the two status outputs never overlap.
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.q      = q_q;
  assign bus.sout_r = q_q[0];
  assign bus.sout_l = q_q[WIDTH-1];
  assign bus.busy   = (state_q == ST_BUSY);
  assign bus.done   = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Testbench for universal_shift_register.
//   dut_a: WIDTH=4, CNT_W=4 -- table-driven vectors plus reset/abort sequence.
//   dut_b: WIDTH=8, CNT_W=5 -- long rotate burst.
// Expected values are pushed into a scoreboard queue as stimulus is driven
// and popped/compared one cycle later, after the active edge.
module tb_universal_shift_register;
  import shift_reg_pkg::*;

  logic clk;
  logic rst;

  universal_shift_register_if #(.WIDTH(4), .CNT_W(4)) bus_a ();
  universal_shift_register_if #(.WIDTH(8), .CNT_W(5)) bus_b ();

  universal_shift_register #(.WIDTH(4), .CNT_W(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  universal_shift_register #(.WIDTH(8), .CNT_W(5)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    mode_t      mode;
    logic       sin_r;
    logic       sin_l;
    logic [3:0] d_load;
    logic       start;
    logic [3:0] count;
    logic [3:0] exp_q;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic       busy;
    logic       done;
  } exp_t;

  vec_t vecs[30];
  exp_t sb_q[$];
  int   checks;
  int   failures;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input vec_t v);
    bus_a.en     = v.en;
    bus_a.mode   = v.mode;
    bus_a.sin_r  = v.sin_r;
    bus_a.sin_l  = v.sin_l;
    bus_a.d_load = v.d_load;
    bus_a.start  = v.start;
    bus_a.count  = v.count;
  endtask

  function automatic vec_t mk(input logic en, input mode_t mode, input logic sr, input logic sl,
                              input logic [3:0] dl, input logic st, input logic [3:0] cnt,
                              input logic [3:0] eq, input logic eb, input logic ed);
    vec_t v;
    v.en = en; v.mode = mode; v.sin_r = sr; v.sin_l = sl; v.d_load = dl;
    v.start = st; v.count = cnt; v.exp_q = eq; v.exp_busy = eb; v.exp_done = ed;
    return v;
  endfunction

  // Pop one expected record and compare against dut_a.
  task automatic compare_a(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb_q.pop_front();
    check({tag, ".q"}, 32'(bus_a.q), 32'(e.q[3:0]));
    check({tag, ".busy"}, 32'(bus_a.busy), 32'(e.busy));
    check({tag, ".done"}, 32'(bus_a.done), 32'(e.done));
    check({tag, ".sout_r"}, 32'(bus_a.sout_r), 32'(e.q[0]));
    check({tag, ".sout_l"}, 32'(bus_a.sout_l), 32'(e.q[3]));
    $display("%s q=%b busy=%b done=%b", tag, bus_a.q, bus_a.busy, bus_a.done);
  endtask

  function automatic exp_t mk_exp(input logic [7:0] q, input logic b, input logic d);
    exp_t e;
    e.q = q; e.busy = b; e.done = d;
    return e;
  endfunction

  initial begin
    int n;
    checks   = 0;
    failures = 0;

    //            en mode       sr sl dl       st cnt   exp_q   busy done
    vecs[0]  = mk(1, MODE_SHR,  1, 0, 4'h0,    0, 4'd0, 4'b1000, 0, 0);
    vecs[1]  = mk(1, MODE_SHR,  0, 0, 4'h0,    0, 4'd0, 4'b0100, 0, 0);
    vecs[2]  = mk(1, MODE_SHR,  1, 0, 4'h0,    0, 4'd0, 4'b1010, 0, 0);
    vecs[3]  = mk(1, MODE_SHR,  1, 0, 4'h0,    0, 4'd0, 4'b1101, 0, 0);
    vecs[4]  = mk(0, MODE_CLR,  0, 0, 4'h0,    0, 4'd0, 4'b1101, 0, 0);
    vecs[5]  = mk(1, MODE_LOAD, 0, 0, 4'b1001, 0, 4'd0, 4'b1001, 0, 0);
    vecs[6]  = mk(1, MODE_ROL,  0, 0, 4'h0,    0, 4'd0, 4'b0011, 0, 0);
    vecs[7]  = mk(1, MODE_LOAD, 0, 0, 4'b1000, 0, 4'd0, 4'b1000, 0, 0);
    vecs[8]  = mk(1, MODE_ASR,  0, 0, 4'h0,    0, 4'd0, 4'b1100, 0, 0);
    vecs[9]  = mk(1, MODE_ASR,  0, 0, 4'h0,    0, 4'd0, 4'b1110, 0, 0);
    vecs[10] = mk(1, MODE_LOAD, 0, 0, 4'b0110, 0, 4'd0, 4'b0110, 0, 0);
    vecs[11] = mk(1, MODE_SHL,  0, 1, 4'h0,    0, 4'd0, 4'b1101, 0, 0);
    vecs[12] = mk(1, MODE_ROR,  0, 0, 4'h0,    0, 4'd0, 4'b1110, 0, 0);
    vecs[13] = mk(1, MODE_HOLD, 1, 1, 4'hf,    0, 4'd0, 4'b1110, 0, 0);
    vecs[14] = mk(1, MODE_CLR,  0, 0, 4'h0,    0, 4'd0, 4'b0000, 0, 0);
    vecs[15] = mk(1, MODE_LOAD, 0, 0, 4'b1011, 0, 4'd0, 4'b1011, 0, 0);
    // ROR burst of 3; controls toggled mid-burst must be ignored
    vecs[16] = mk(1, MODE_ROR,  0, 0, 4'h0,    1, 4'd3, 4'b1011, 1, 0);
    vecs[17] = mk(1, MODE_CLR,  0, 0, 4'h0,    1, 4'd0, 4'b1101, 1, 0);
    vecs[18] = mk(0, MODE_LOAD, 0, 0, 4'b0000, 0, 4'd9, 4'b1110, 1, 0);
    vecs[19] = mk(0, MODE_HOLD, 0, 0, 4'h0,    0, 4'd0, 4'b0111, 0, 1);
    // start with count=0 in the done cycle; start outranks en=1/CLR
    vecs[20] = mk(1, MODE_CLR,  0, 0, 4'h0,    1, 4'd0, 4'b0111, 0, 1);
    vecs[21] = mk(0, MODE_HOLD, 0, 0, 4'h0,    0, 4'd0, 4'b0111, 0, 0);
    // SHL burst of 2 with live sin_l, then back-to-back SHR burst of 1
    vecs[22] = mk(0, MODE_SHL,  0, 1, 4'h0,    1, 4'd2, 4'b0111, 1, 0);
    vecs[23] = mk(0, MODE_HOLD, 0, 0, 4'h0,    0, 4'd0, 4'b1110, 1, 0);
    vecs[24] = mk(0, MODE_HOLD, 0, 1, 4'h0,    0, 4'd0, 4'b1101, 0, 1);
    vecs[25] = mk(0, MODE_SHR,  0, 0, 4'h0,    1, 4'd1, 4'b1101, 1, 0);
    vecs[26] = mk(0, MODE_HOLD, 1, 0, 4'h0,    0, 4'd0, 4'b1110, 0, 1);
    vecs[27] = mk(0, MODE_HOLD, 0, 0, 4'h0,    0, 4'd0, 4'b1110, 0, 0);
    // LOAD burst samples d_load live on the burst edge
    vecs[28] = mk(0, MODE_LOAD, 0, 0, 4'b0000, 1, 4'd1, 4'b1110, 1, 0);
    vecs[29] = mk(0, MODE_HOLD, 0, 0, 4'b0101, 0, 4'd0, 4'b0101, 0, 1);

    // ---- reset ----
    rst = 1'b0;
    drive_a(mk(0, MODE_HOLD, 0, 0, 4'h0, 0, 4'd0, 4'h0, 0, 0));
    bus_b.en = 1'b0; bus_b.mode = MODE_HOLD; bus_b.sin_r = 1'b0; bus_b.sin_l = 1'b0;
    bus_b.d_load = '0; bus_b.start = 1'b0; bus_b.count = '0;
    tick();
    tick();
    sb_q.push_back(mk_exp(8'h00, 0, 0));
    compare_a("reset");
    rst = 1'b1;

    // ---- table-driven vectors ----
    for (int i = 0; i < 30; i++) begin
      drive_a(vecs[i]);
      sb_q.push_back(mk_exp({4'h0, vecs[i].exp_q}, vecs[i].exp_busy, vecs[i].exp_done));
      tick();
      compare_a($sformatf("vec%0d", i));
    end

    // ---- reset asserted mid-burst aborts it ----
    drive_a(mk(0, MODE_ROL, 0, 0, 4'h0, 1, 4'd5, 4'h0, 0, 0));
    sb_q.push_back(mk_exp(8'h05, 1, 0));
    tick();
    compare_a("abort_e0");
    bus_a.start = 1'b0;
    sb_q.push_back(mk_exp(8'h0a, 1, 0));
    tick();
    compare_a("abort_e1");
    #2 rst = 1'b0;
    #1;
    sb_q.push_back(mk_exp(8'h00, 0, 0));
    compare_a("abort_async");
    tick();
    sb_q.push_back(mk_exp(8'h00, 0, 0));
    compare_a("abort_held");
    rst = 1'b1;
    sb_q.push_back(mk_exp(8'h00, 0, 0));
    tick();
    compare_a("abort_release");
    drive_a(mk(1, MODE_SHR, 1, 0, 4'h0, 0, 4'd0, 4'h0, 0, 0));
    sb_q.push_back(mk_exp(8'h08, 0, 0));
    tick();
    compare_a("abort_step");
    bus_a.en = 1'b0;

    // ---- WIDTH=8 / CNT_W=5: ROL 0x01 for 31 cycles ----
    bus_b.en = 1'b1; bus_b.mode = MODE_LOAD; bus_b.d_load = 8'h01;
    tick();
    check("b_load.q", 32'(bus_b.q), 32'h01);
    bus_b.en = 1'b0; bus_b.mode = MODE_ROL; bus_b.start = 1'b1; bus_b.count = 5'd31;
    tick();
    check("b_e0.busy", 32'(bus_b.busy), 32'd1);
    bus_b.start = 1'b0;
    n = 0;
    while (bus_b.done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("b_burst_len", 32'(n), 32'd31);
    check("b_done.q", 32'(bus_b.q), 32'h80);
    check("b_done.busy", 32'(bus_b.busy), 32'd0);
    check("b_done.sout_l", 32'(bus_b.sout_l), 32'd1);
    check("b_done.sout_r", 32'(bus_b.sout_r), 32'd0);
    $display("b_burst cycles=%0d q=%h", n, bus_b.q);
    tick();
    check("b_after.done", 32'(bus_b.done), 32'd0);
    check("b_after.q", 32'(bus_b.q), 32'h80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
